// File: rtl/pulse_gen_mc.sv
// Multi-channel programmable pulse generator: each channel turns a rising trigger
// edge into a delayed pulse of programmable width, with retrigger, abort and status strobes.
module pulse_gen_mc #(
    parameter int CH     = 4,
    parameter int CW     = 8,
    parameter int RETRIG = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] trig,
    input  logic [CH-1:0] abort,
    input  logic [CW-1:0] cfg_delay,
    input  logic [CW-1:0] cfg_width,
    output logic [CH-1:0] dout,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] done,
    output logic [CH-1:0] miss
);

    typedef enum logic [1:0] {IDLE, DLY, HIGH} state_t;

    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] ZERO = '0;

    logic [CH-1:0] trig_d_reg;
    logic [CH-1:0] ev;

    // Edge history keeps tracking trig even while a channel is aborted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_d_reg <= '0;
        end else begin
            trig_d_reg <= trig;
        end
    end

    assign ev = trig & ~trig_d_reg;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            state_t        state_reg;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] width_reg;
            logic          dout_reg;
            logic          busy_reg;
            logic          done_reg;
            logic          miss_reg;
            logic          restart;

            // A retrigger is only honoured with a non-zero width.
            assign restart = (RETRIG != 0) && ev[gi] && (cfg_width != ZERO);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    width_reg <= '0;
                    dout_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    miss_reg  <= 1'b0;
                end else begin
                    done_reg <= 1'b0;
                    miss_reg <= 1'b0;
                    if (abort[gi]) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        dout_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else begin
                        case (state_reg)
                            IDLE: begin
                                if (ev[gi]) begin
                                    if (cfg_width == ZERO) begin
                                        miss_reg <= 1'b1;
                                    end else if (cfg_delay == ZERO) begin
                                        state_reg <= HIGH;
                                        cnt_reg   <= cfg_width - ONE;
                                        dout_reg  <= 1'b1;
                                        busy_reg  <= 1'b1;
                                    end else begin
                                        state_reg <= DLY;
                                        cnt_reg   <= cfg_delay - ONE;
                                        width_reg <= cfg_width;
                                        busy_reg  <= 1'b1;
                                    end
                                end
                            end
                            DLY: begin
                                if (restart) begin
                                    if (cfg_delay == ZERO) begin
                                        state_reg <= HIGH;
                                        cnt_reg   <= cfg_width - ONE;
                                        dout_reg  <= 1'b1;
                                    end else begin
                                        cnt_reg   <= cfg_delay - ONE;
                                        width_reg <= cfg_width;
                                    end
                                end else begin
                                    miss_reg <= ev[gi];
                                    if (cnt_reg == ZERO) begin
                                        state_reg <= HIGH;
                                        cnt_reg   <= width_reg - ONE;
                                        dout_reg  <= 1'b1;
                                    end else begin
                                        cnt_reg <= cnt_reg - ONE;
                                    end
                                end
                            end
                            HIGH: begin
                                // Reload wins over completion, so a retrigger on the last edge extends the pulse.
                                if (restart) begin
                                    cnt_reg <= cfg_width - ONE;
                                end else begin
                                    miss_reg <= ev[gi];
                                    if (cnt_reg == ZERO) begin
                                        state_reg <= IDLE;
                                        dout_reg  <= 1'b0;
                                        busy_reg  <= 1'b0;
                                        done_reg  <= 1'b1;
                                    end else begin
                                        cnt_reg <= cnt_reg - ONE;
                                    end
                                end
                            end
                            default: begin
                                state_reg <= IDLE;
                                cnt_reg   <= '0;
                                dout_reg  <= 1'b0;
                                busy_reg  <= 1'b0;
                            end
                        endcase
                    end
                end
            end

            assign dout[gi] = dout_reg;
            assign busy[gi] = busy_reg;
            assign done[gi] = done_reg;
            assign miss[gi] = miss_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pulse_gen_mc.sv
// Bench for pulse_gen_mc: one instance per retrigger mode, a timestamp-based
// reference model, a vector table, directed corner sequences and random traffic.
module tb_pulse_gen_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] trig, abort;
    logic [7:0] cfg_delay, cfg_width;
    logic [3:0] dout0, busy0, done0, miss0;
    logic [3:0] dout1, busy1, done1, miss1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pulse_gen_mc #(.CH(4), .CW(8), .RETRIG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .trig(trig), .abort(abort),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width),
        .dout(dout0), .busy(busy0), .done(done0), .miss(miss0));

    pulse_gen_mc #(.CH(4), .CW(8), .RETRIG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .trig(trig), .abort(abort),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width),
        .dout(dout1), .busy(busy1), .done(done1), .miss(miss1));

    // Reference model: each busy channel is described by the absolute edge
    // numbers of its first and last high cycle.
    int         t_edge = 0;
    logic [3:0] m_trig_d = '0;
    bit         m_busy [2][4];
    int         m_hs   [2][4];
    int         m_he   [2][4];
    logic [15:0] m_exp [2];

    task automatic model_edge();
        logic [3:0] ev;
        int d, w;
        ev = trig & ~m_trig_d;
        d  = int'(cfg_delay);
        w  = int'(cfg_width);
        for (int r = 0; r < 2; r++) begin
            logic [3:0] e_dout, e_busy, e_done, e_miss;
            e_dout = '0; e_busy = '0; e_done = '0; e_miss = '0;
            for (int c = 0; c < 4; c++) begin
                if (!rst_n || abort[c]) begin
                    m_busy[r][c] = 0;
                end else if (!m_busy[r][c]) begin
                    if (ev[c]) begin
                        if (w == 0) begin
                            e_miss[c] = 1'b1;
                        end else begin
                            m_busy[r][c] = 1;
                            m_hs[r][c] = t_edge + d;
                            m_he[r][c] = t_edge + d + w - 1;
                        end
                    end
                end else if (ev[c] && r == 1 && w != 0) begin
                    if (t_edge <= m_hs[r][c]) begin
                        m_hs[r][c] = t_edge + d;
                        m_he[r][c] = t_edge + d + w - 1;
                    end else begin
                        m_he[r][c] = t_edge + w - 1;
                    end
                end else begin
                    if (ev[c]) e_miss[c] = 1'b1;
                    if (t_edge == m_he[r][c] + 1) begin
                        e_done[c] = 1'b1;
                        m_busy[r][c] = 0;
                    end
                end
                e_busy[c] = m_busy[r][c];
                e_dout[c] = m_busy[r][c] && t_edge >= m_hs[r][c] && t_edge <= m_he[r][c];
            end
            m_exp[r] = {e_dout, e_busy, e_done, e_miss};
        end
        m_trig_d = rst_n ? trig : 4'b0000;
        t_edge++;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=%h expected=%h", name, t_edge - 1, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_r0", {16'h0, dout0, busy0, done0, miss0}, {16'h0, m_exp[0]});
        check("model_r1", {16'h0, dout1, busy1, done1, miss1}, {16'h0, m_exp[1]});
    endtask

    typedef struct {
        logic       rst_n;
        logic [3:0] trig;
        logic [3:0] abort;
        logic [7:0] d, w;
        logic [3:0] e_dout, e_busy, e_done, e_miss;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic [3:0] tg, logic [3:0] ab, logic [7:0] d, logic [7:0] w,
                                logic [3:0] ed, logic [3:0] eb, logic [3:0] edn, logic [3:0] em);
        vec_t v;
        v.rst_n = r; v.trig = tg; v.abort = ab; v.d = d; v.w = w;
        v.e_dout = ed; v.e_busy = eb; v.e_done = edn; v.e_miss = em;
        tbl.push_back(v);
    endfunction

    task automatic set_in(logic [3:0] tg, logic [3:0] ab, logic [7:0] d, logic [7:0] w);
        trig = tg; abort = ab; cfg_delay = d; cfg_width = w;
    endtask

    task automatic idle_ticks(int n);
        set_in(4'b0000, 4'b0000, 8'd0, 8'd1);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int k, h, ndone, nhigh;
        rst_n = 1'b0;
        set_in(4'b1111, 4'b0000, 8'd0, 8'd3);

        // Reset with triggers held, then release with d=0/w=3; then channel 0 with d=5/w=4.
        for (int i = 0; i < 3; i++) add(1'b0, 4'hF, 4'h0, 8'd0, 8'd3, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1'b1, 4'hF, 4'h0, 8'd0, 8'd3, 4'hF, 4'hF, 4'h0, 4'h0);
        add(1'b1, 4'hF, 4'h0, 8'd0, 8'd3, 4'hF, 4'hF, 4'h0, 4'h0);
        add(1'b1, 4'hF, 4'h0, 8'd0, 8'd3, 4'hF, 4'hF, 4'h0, 4'h0);
        add(1'b1, 4'hF, 4'h0, 8'd0, 8'd3, 4'h0, 4'h0, 4'hF, 4'h0);
        add(1'b1, 4'h0, 4'h0, 8'd0, 8'd3, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1'b1, 4'h1, 4'h0, 8'd5, 8'd4, 4'h0, 4'h1, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) add(1'b1, 4'h0, 4'h0, 8'd5, 8'd4, 4'h0, 4'h1, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) add(1'b1, 4'h0, 4'h0, 8'd5, 8'd4, 4'h1, 4'h1, 4'h0, 4'h0);
        add(1'b1, 4'h0, 4'h0, 8'd5, 8'd4, 4'h0, 4'h0, 4'h1, 4'h0);
        add(1'b1, 4'h0, 4'h0, 8'd5, 8'd4, 4'h0, 4'h0, 4'h0, 4'h0);

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n;
            set_in(tbl[i].trig, tbl[i].abort, tbl[i].d, tbl[i].w);
            tick();
            check($sformatf("tbl[%0d]", i), {16'h0, dout0, busy0, done0, miss0},
                  {16'h0, tbl[i].e_dout, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_miss});
        end

        // Busy retrigger ignored in mode 0: mid-pulse, then on the final high edge.
        set_in(4'b0010, 4'b0000, 8'd0, 8'd10); tick();
        set_in(4'b0000, 4'b0000, 8'd0, 8'd10); for (int i = 1; i < 4; i++) tick();
        set_in(4'b0010, 4'b0000, 8'd0, 8'd10); tick();
        check("r0_miss_midpulse", {28'h0, miss0}, 32'h2);
        check("r0_dout_kept", {31'h0, dout0[1]}, 32'h1);
        set_in(4'b0000, 4'b0000, 8'd0, 8'd10); for (int i = 5; i < 10; i++) tick();
        tick();
        check("r0_done_t10", {28'h0, done0}, 32'h2);
        idle_ticks(20);
        set_in(4'b0010, 4'b0000, 8'd0, 8'd10); tick();
        set_in(4'b0000, 4'b0000, 8'd0, 8'd10); for (int i = 1; i < 10; i++) tick();
        set_in(4'b0010, 4'b0000, 8'd0, 8'd10); tick();
        check("r0_done_and_miss", {24'h0, done0, miss0}, 32'h22);
        idle_ticks(20);

        // Mode 1: extend during HIGH, restart during DLY.
        ndone = 0; nhigh = 0;
        set_in(4'b0100, 4'b0000, 8'd0, 8'd10); tick();
        nhigh += dout1[2];
        set_in(4'b0000, 4'b0000, 8'd0, 8'd10);
        for (int i = 1; i < 12; i++) begin
            if (i == 6) set_in(4'b0100, 4'b0000, 8'd0, 8'd5);
            else        set_in(4'b0000, 4'b0000, 8'd0, 8'd5);
            tick();
            nhigh += dout1[2];
            ndone += done1[2];
            if (i == 6) check("r1_no_miss", {28'h0, miss1}, 32'h0);
            if (i == 10) check("r1_dout_t10", {31'h0, dout1[2]}, 32'h1);
        end
        check("r1_high_cycles", nhigh, 32'd11);
        check("r1_single_done", ndone, 32'd1);
        idle_ticks(20);
        set_in(4'b0100, 4'b0000, 8'd5, 8'd4); tick();
        set_in(4'b0000, 4'b0000, 8'd5, 8'd4); tick(); tick();
        set_in(4'b0100, 4'b0000, 8'd3, 8'd4); tick();
        set_in(4'b0000, 4'b0000, 8'd3, 8'd4); tick(); tick();
        check("dly_restart_r1_t5", {30'h0, dout1[2], dout0[2]}, 32'h1);
        tick();
        check("dly_restart_r1_t6", {31'h0, dout1[2]}, 32'h1);
        idle_ticks(20);

        // Abort in HIGH, then abort coincident with a trigger edge.
        set_in(4'b1000, 4'b0000, 8'd2, 8'd8); tick();
        set_in(4'b0000, 4'b0000, 8'd2, 8'd8); for (int i = 1; i < 5; i++) tick();
        set_in(4'b0000, 4'b1000, 8'd2, 8'd8); tick();
        check("abort_clears", {24'h0, dout0, busy0}, 32'h0);
        ndone = 0;
        set_in(4'b0000, 4'b0000, 8'd2, 8'd8);
        for (int i = 0; i < 10; i++) begin tick(); ndone += done0[3]; end
        check("abort_no_done", ndone, 32'd0);
        set_in(4'b1000, 4'b1000, 8'd0, 8'd4); tick();
        check("abort_with_trig", {24'h0, busy0, miss0}, 32'h0);
        idle_ticks(5);

        // Zero width is dropped; then the longest delay and width.
        set_in(4'b0001, 4'b0000, 8'd3, 8'd0); tick();
        check("w0_miss", {20'h0, dout0, busy0, miss0}, 32'h1);
        idle_ticks(3);
        set_in(4'b0001, 4'b0000, 8'd255, 8'd255); tick();
        set_in(4'b0000, 4'b0000, 8'd0, 8'd1);
        k = 0;
        while (!dout0[0] && k < 600) begin tick(); k++; end
        check("max_delay", k, 32'd255);
        h = 1;
        while (dout0[0] && h < 600) begin tick(); if (dout0[0]) h++; end
        check("max_width", h, 32'd255);
        check("max_done", {31'h0, done0[0]}, 32'h1);
        idle_ticks(5);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] tg, ab;
            for (int c = 0; c < 4; c++) begin
                tg[c] = ($urandom_range(0, 3) == 0) ? ~trig[c] : trig[c];
                ab[c] = ($urandom_range(0, 60) == 0);
            end
            rst_n = ($urandom_range(0, 500) != 0);
            set_in(tg, ab, 8'($urandom_range(0, 6)), 8'($urandom_range(0, 7)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
